// File: rtl/rx_packet_reader_pkg.sv
// Shared constants for the RX packet path: header bit-fields, packet geometry
// and the reader FSM state encoding.
package rx_packet_reader_pkg;

  // FIFO geometry (log2 depths)
  localparam int PH_FIFO_SZ_L2     = 7;
  localparam int CD_FIFO_SZ_L2     = 10;

  // Emitted packet geometry, in 16-bit words
  localparam int PKT_WORDS         = 256;
  localparam int HDR_WORDS         = 4;
  localparam int MAX_PAYLOAD_BYTES = 504;

  // Header bit-fields inside the 64-bit header FIFO word
  localparam int HDR_LEN_LSB       = 0;
  localparam int HDR_LEN_MSB       = 8;
  localparam int HDR_OVERRUN_BIT   = 31;
  localparam int HDR_TS_LSB        = 32;
  localparam int HDR_TS_MSB        = 63;

  localparam int LEN_W             = HDR_LEN_MSB - HDR_LEN_LSB + 1;
  localparam int CNT_W             = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_PAD  = 2'd3
  } state_e;

  // Header word k (k = 0..3) as it appears on the packet stream
  function automatic logic [15:0] hdr_word(input logic [63:0] hdr, input logic [1:0] k);
    return hdr[{k, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/rx_pkt_len_check.sv
// Payload length sanitiser: rounds the byte count down to a whole number of
// 16-bit words, caps it at the maximum payload, and flags any length that
// needed changing (odd, or beyond the maximum).
module rx_pkt_len_check
  import rx_packet_reader_pkg::*;
(
  input  logic [LEN_W-1:0] len_i,
  output logic [LEN_W-1:0] len_o,
  output logic             err_o
);

  logic [LEN_W-1:0] even_len;

  // Clamp to min(len & ~1, MAX) and raise the error flag for illegal lengths
  always_comb begin
    even_len = {len_i[LEN_W-1:1], 1'b0};
    err_o    = len_i[0] || (len_i > LEN_W'(MAX_PAYLOAD_BYTES));
    len_o    = (even_len > LEN_W'(MAX_PAYLOAD_BYTES)) ? LEN_W'(MAX_PAYLOAD_BYTES) : even_len;
  end

endmodule

// File: rtl/rx_packet_reader.sv
// RX packet reader: pops one header from the header FIFO once its whole
// payload is buffered in the channel data FIFO, then streams a fixed
// 256-word packet: 4 header words, payload words, zero padding.
//
// Output stream handshake: a word transfers on a rising edge of rdclk where
// out_valid_o && out_ready_i. While out_valid_o is high and out_ready_i is
// low, out_data_o/out_sop_o/out_eop_o hold; out_valid_o only drops inside a
// packet if the data FIFO unexpectedly runs empty in DATA.
module rx_packet_reader
  import rx_packet_reader_pkg::*;
#(
  parameter int CD_USEDW_W = CD_FIFO_SZ_L2
) (
  input  logic                  rdclk,
  input  logic                  reset,
  input  logic [63:0]           ph_data_i,
  input  logic                  ph_empty_i,
  output logic                  ph_rdreq_o,
  input  logic [15:0]           cd_data_i,
  input  logic                  cd_empty_i,
  input  logic                  cd_full_i,
  input  logic [CD_USEDW_W-1:0] cd_usedw_i,
  output logic                  cd_rdreq_o,
  output logic [15:0]           out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_sop_o,
  output logic                  out_eop_o,
  output logic                  len_err_o,
  output logic [1:0]            dbg_state_o
);

  state_e           state_q, state_d;
  logic [63:0]      hdr_q, hdr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       need_q, need_d;

  logic [LEN_W-1:0] len_clamped;
  logic             len_bad;
  logic [7:0]       need_now;
  logic             start;
  logic             accept;

  rx_pkt_len_check u_len_check (
    .len_i (ph_data_i[HDR_LEN_MSB:HDR_LEN_LSB]),
    .len_o (len_clamped),
    .err_o (len_bad)
  );

  // Payload words required by the header at the FIFO head
  assign need_now = len_clamped[LEN_W-1:1];

  // Start only when the entire payload is already buffered, so DATA never
  // starves; reset masks the pop so the FIFOs are untouched while held.
  assign start = !reset && !ph_empty_i &&
                 (cd_full_i || (int'(cd_usedw_i) >= int'(need_now)));

  assign accept      = out_valid_o && out_ready_i;
  assign dbg_state_o = state_q;

  // State, latched header, payload length and accepted-word counter
  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      cnt_q   <= '0;
      need_q  <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      need_q  <= need_d;
    end
  end

  // Next-state and stream outputs
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    cnt_d       = cnt_q;
    need_d      = need_q;
    ph_rdreq_o  = 1'b0;
    len_err_o   = 1'b0;
    cd_rdreq_o  = 1'b0;
    out_data_o  = '0;
    out_valid_o = 1'b0;
    out_sop_o   = 1'b0;
    out_eop_o   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          ph_rdreq_o = 1'b1;
          len_err_o  = len_bad;
          // Emitted header word 0 carries the clamped length
          hdr_d      = {ph_data_i[63:HDR_LEN_MSB+1], len_clamped};
          need_d     = need_now;
          state_d    = ST_HDR;
        end
      end

      ST_HDR: begin
        out_valid_o = 1'b1;
        out_data_o  = hdr_word(hdr_q, cnt_q[1:0]);
        out_sop_o   = (cnt_q == '0);
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(HDR_WORDS - 1)) begin
            state_d = (need_q != '0) ? ST_DATA : ST_PAD;
          end
        end
      end

      ST_DATA: begin
        // Stall rather than pop an empty FIFO
        out_valid_o = !cd_empty_i;
        out_data_o  = cd_data_i;
        out_eop_o   = (cnt_q == CNT_W'(PKT_WORDS - 1));
        cd_rdreq_o  = accept;
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(PKT_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else if (cnt_q == CNT_W'(HDR_WORDS - 1) + {1'b0, need_q}) begin
            state_d = ST_PAD;
          end
        end
      end

      ST_PAD: begin
        out_valid_o = 1'b1;
        out_eop_o   = (cnt_q == CNT_W'(PKT_WORDS - 1));
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (out_eop_o) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
